shift_deser: RTL and testbench
==============================

Name: shift_deser

Overview:
- Serial-in / parallel-out deserializer.
- Receiving end of the team's 4-bit PISO shift-register link.
- Collects WIDTH serial bits, MSB first, qualified by a bit-valid strobe and framed by a start flag.
- Presents the assembled word on a valid/ready output register with overrun detection, for consumption by downstream parallel logic.

Parameters:
- WIDTH, 4, data word width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH+1), bit-counter width; derived, not overridden.

Ports:
- i_clk  input  1  system clock; all logic on its rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_start  input  1  marks the current bit as the first bit of a frame; only meaningful with i_bit_vld.
- i_bit_vld  input  1  i_data holds a valid serial bit this cycle.
- i_data  input  1  serial data bit, MSB first.
- i_ready  input  1  downstream accepts o_data this cycle.
- o_data  output  WIDTH  assembled parallel word.
- o_valid  output  1  o_data holds an unconsumed word.
- o_overrun  output  1  one-cycle pulse: a word completed while the output was still occupied and was dropped.
- o_busy  output  1  frame in progress (FSM not IDLE).

Behaviour:
- Reset (i_rst=1 at a clock edge):
  - o_data=0, o_valid=0, o_overrun=0, o_busy=0.
  - FSM goes to IDLE; bit counter=0; shift register=0.
  - Reset wins over every other input and aborts any partial frame.
- FSM states: IDLE, RECV, PAR (PAR exists only with DESER_PARITY_EN).
- IDLE:
  - i_bit_vld & i_start: shift register <= {sreg[WIDTH-2:0], i_data}; counter=1; go to RECV.
  - i_bit_vld without i_start: bit ignored.
- RECV:
  - i_bit_vld=0: hold all state.
  - i_bit_vld=1: shift in i_data; counter+1.
  - On the bit that makes counter==WIDTH: word complete; go to IDLE, or to PAR when parity is enabled.
  - i_start & i_bit_vld in RECV: partial frame discarded; this bit becomes bit 1 of a new frame (counter=1). No output and no error.
- Word delivery:
  - The complete word is written to o_data, with o_valid=1, on the clock edge after the last bit is sampled (1-cycle latency).
  - The output latch happens at RECV→IDLE, or at PAR→IDLE when parity is enabled.
- Output handshake:
  - o_valid stays high, and o_data stays stable, until i_ready=1.
  - Transfer occurs on any cycle with o_valid & i_ready; o_valid clears on the next edge unless a new word lands on that same edge.
  - Completion while o_valid=1 and i_ready=1: old word consumed and new word loaded in the same edge; o_valid stays 1; no overrun.
  - Completion while o_valid=1 and i_ready=0: new word dropped, o_data keeps the old word, o_overrun pulses high for exactly one cycle.
- o_busy = (state != IDLE).
- i_ready with o_valid=0 has no effect.
- The counter never exceeds WIDTH and is cleared to 0 on return to IDLE.

Optional Feature:
- Macro: DESER_PARITY_EN.
- Defined:
  - After WIDTH data bits, FSM enters PAR and waits for one more i_bit_vld bit, the even-parity bit.
  - Word is delivered on the PAR→IDLE transition.
  - Extra output o_perr (1 bit) is registered alongside o_data: 1 when XOR(word, parity bit) != 0. It is held and cleared with o_valid; reset value 0.
  - i_start during PAR restarts the frame, as in RECV.
- Undefined:
  - No PAR state and no o_perr port.
  - Word is delivered immediately after the last data bit.

Decomposition:
- Shared package shift_pkg holds:
  - FSM state enum (ST_IDLE, ST_RECV, ST_PAR).
  - Default WIDTH constant (4), shared with the PISO transmitter.
- Natural sub-module: shift_deser_outreg, the one-entry valid/ready output register with overrun pulse generation.
- The FSM and shift register stay in the top module.

Test Plan:
- Reset then frame: i_rst=1 for 2 cycles, then 0 → all outputs 0. Frame bits 1,0,1,0 with i_start on the first bit → o_data=4'hA and o_valid=1 one cycle after the 4th bit; i_ready=1 → o_valid=0 on the next edge.
- Gapped bits: same frame 1,1,0,0 with i_bit_vld low for 3 cycles between bits 2 and 3 → o_data=4'hC; o_busy=1 throughout, including the gaps.
- Mid-frame restart: send 1,0, then i_start with 0,1,1,1 → o_data=4'h7; no o_overrun.
- Overrun: hold i_ready=0; send 4'hA, then 4'h5 → o_overrun pulses for 1 cycle and o_data stays 4'hA. Repeat with i_ready=1 on the completion edge → o_data=4'h5, o_valid stays 1, no o_overrun.
- Reset mid-frame: assert i_rst after 2 bits → o_busy=0, o_valid=0. A following full frame of 4'h3 is received correctly.
- Parity (DESER_PARITY_EN): 4'hA with parity bit 0 → o_perr=0; 4'hA with parity bit 1 → o_perr=1; o_data=4'hA in both cases.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the 4-bit shift-register link (PISO transmitter / SIPO receiver).
// Holds the receiver FSM encoding, default word width and the even-parity helper.
package shift_pkg;

    localparam int DESER_WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_PAR  = 2'd2
    } deser_state_e;

    // Even parity: a correct parity bit makes the XOR of word and parity bit zero.
    function automatic logic even_par_err(input logic [31:0] word, input logic par_bit);
        return (^word) ^ par_bit;
    endfunction

endpackage

// File: rtl/shift_deser_outreg.sv
// One-entry valid/ready output register with a single-cycle overrun pulse.
// With DESER_PARITY_EN defined it also carries the parity-error flag.
module shift_deser_outreg
    import shift_pkg::*;
#(
    parameter int WIDTH = DESER_WIDTH_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_word,
`ifdef DESER_PARITY_EN
    input  logic             i_perr,
    output logic             o_perr,
`endif
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_overrun
);

    logic [WIDTH-1:0] data_r;
    logic             valid_r;
    logic             overrun_r;
`ifdef DESER_PARITY_EN
    logic             perr_r;
`endif

    // Output slot: load when empty or being drained this edge, otherwise drop and flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            data_r    <= {WIDTH{1'b0}};
            valid_r   <= 1'b0;
            overrun_r <= 1'b0;
`ifdef DESER_PARITY_EN
            perr_r    <= 1'b0;
`endif
        end else begin
            overrun_r <= i_load & valid_r & ~i_ready;
            if (i_load && (!valid_r || i_ready)) begin
                data_r  <= i_word;
                valid_r <= 1'b1;
`ifdef DESER_PARITY_EN
                perr_r  <= i_perr;
`endif
            end else if (valid_r && i_ready) begin
                valid_r <= 1'b0;
`ifdef DESER_PARITY_EN
                perr_r  <= 1'b0;
`endif
            end
        end
    end

    assign o_data    = data_r;
    assign o_valid   = valid_r;
    assign o_overrun = overrun_r;
`ifdef DESER_PARITY_EN
    assign o_perr    = perr_r;
`endif

endmodule

// File: rtl/shift_deser.sv
// Serial-in/parallel-out deserializer: MSB-first frames framed by i_start, delivered on valid/ready.
// Optional even-parity bit after each word when DESER_PARITY_EN is defined.
module shift_deser
    import shift_pkg::*;
#(
    parameter int WIDTH = DESER_WIDTH_DEFAULT,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_bit_vld,
    input  logic             i_data,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_overrun,
`ifdef DESER_PARITY_EN
    output logic             o_perr,
`endif
    output logic             o_busy
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    deser_state_e     state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [WIDTH-1:0] sreg_r, sreg_s;
    logic [WIDTH-1:0] shifted_s;
    logic [WIDTH-1:0] word_s;
    logic             load_s;
    logic             busy_r;
`ifdef DESER_PARITY_EN
    logic             perr_s;
`endif

    assign shifted_s = {sreg_r[WIDTH-2:0], i_data};

    // State, bit counter, shift register and busy flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            sreg_r  <= {WIDTH{1'b0}};
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            sreg_r  <= sreg_s;
            busy_r  <= (state_s != ST_IDLE);
        end
    end

    // Next-state logic; a start-qualified bit in any state opens a fresh frame.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        sreg_s  = sreg_r;
        load_s  = 1'b0;
        word_s  = sreg_r;
`ifdef DESER_PARITY_EN
        perr_s  = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                if (i_bit_vld && i_start) begin
                    sreg_s  = shifted_s;
                    cnt_s   = CNT_ONE;
                    state_s = ST_RECV;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RECV: begin
                if (i_bit_vld) begin
                    sreg_s = shifted_s;
                    if (i_start) begin
                        cnt_s = CNT_ONE;
                    end else if (cnt_r == CNT_LAST) begin
`ifdef DESER_PARITY_EN
                        cnt_s   = CNT_W'(WIDTH);
                        state_s = ST_PAR;
`else
                        cnt_s   = {CNT_W{1'b0}};
                        state_s = ST_IDLE;
                        load_s  = 1'b1;
                        word_s  = shifted_s;
`endif
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end else begin
                    state_s = ST_RECV;
                end
            end
`ifdef DESER_PARITY_EN
            ST_PAR: begin
                if (i_bit_vld) begin
                    if (i_start) begin
                        sreg_s  = shifted_s;
                        cnt_s   = CNT_ONE;
                        state_s = ST_RECV;
                    end else begin
                        cnt_s   = {CNT_W{1'b0}};
                        state_s = ST_IDLE;
                        load_s  = 1'b1;
                        word_s  = sreg_r;
                        perr_s  = even_par_err(32'(sreg_r), i_data);
                    end
                end else begin
                    state_s = ST_PAR;
                end
            end
`endif
            default: begin
                state_s = ST_IDLE;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    assign o_busy = busy_r;

    shift_deser_outreg #(
        .WIDTH(WIDTH)
    ) u_outreg (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_load   (load_s),
        .i_word   (word_s),
`ifdef DESER_PARITY_EN
        .i_perr   (perr_s),
        .o_perr   (o_perr),
`endif
        .i_ready  (i_ready),
        .o_data   (o_data),
        .o_valid  (o_valid),
        .o_overrun(o_overrun)
    );

endmodule

// File: tb/tb_shift_deser.sv
// Self-checking bench for shift_deser: directed scenarios plus random traffic
// against a frame-level reference model (honours DESER_PARITY_EN).
module tb_shift_deser;

    localparam int WIDTH = 4;

    logic             i_clk = 1'b0;
    logic             i_rst = 1'b1;
    logic             i_start = 1'b0;
    logic             i_bit_vld = 1'b0;
    logic             i_data = 1'b0;
    logic             i_ready = 1'b0;
    logic [WIDTH-1:0] o_data;
    logic             o_valid;
    logic             o_overrun;
    logic             o_busy;
`ifdef DESER_PARITY_EN
    logic             o_perr;
    logic             par_flip = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model: collected frame bits plus output slot contents.
    int               m_bits[$];
    bit               m_busy;
    logic [WIDTH-1:0] m_data;
    bit               m_valid;
    bit               m_ovr;
    bit               m_perr;

    shift_deser #(.WIDTH(WIDTH)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_start  (i_start),
        .i_bit_vld(i_bit_vld),
        .i_data   (i_data),
        .i_ready  (i_ready),
        .o_data   (o_data),
        .o_valid  (o_valid),
        .o_overrun(o_overrun),
`ifdef DESER_PARITY_EN
        .o_perr   (o_perr),
`endif
        .o_busy   (o_busy)
    );

    always #5 i_clk = ~i_clk;

    // One clock: drive inputs at negedge, advance the model, sample 1 time unit after posedge.
    task automatic step(input logic rst, input logic st, input logic vld, input logic d, input logic rdy);
        int  frame_len;
        int  word;
        bit  done;
        bit  pe;
        @(negedge i_clk);
        i_rst = rst; i_start = st; i_bit_vld = vld; i_data = d; i_ready = rdy;
`ifdef DESER_PARITY_EN
        frame_len = WIDTH + 1;
`else
        frame_len = WIDTH;
`endif
        done = 1'b0; word = 0; pe = 1'b0;
        if (rst) begin
            m_bits.delete(); m_busy = 1'b0;
            m_data = '0; m_valid = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
        end else begin
            if (vld && st) begin
                m_bits = {int'(d)}; m_busy = 1'b1;
            end else if (vld && m_busy) begin
                m_bits.push_back(int'(d));
            end
            if (m_busy && m_bits.size() == frame_len) begin
                done = 1'b1;
                for (int i = 0; i < WIDTH; i++) word = word * 2 + m_bits[i];
                for (int i = 0; i < frame_len; i++) pe = pe ^ m_bits[i][0];
                m_bits.delete(); m_busy = 1'b0;
            end
            m_ovr = done && m_valid && !rdy;
            if (done && (!m_valid || rdy)) begin
                m_data = word[WIDTH-1:0]; m_valid = 1'b1;
`ifdef DESER_PARITY_EN
                m_perr = pe;
`endif
            end else if (m_valid && rdy) begin
                m_valid = 1'b0; m_perr = 1'b0;
            end
        end
        @(posedge i_clk);
        #1;
    endtask

    // Send one frame MSB first with i_start on bit 1; rdy_last is i_ready on the completing bit.
    task automatic send_word(input logic [WIDTH-1:0] w, input logic rdy_last);
        logic [WIDTH-1:0] wv;
        wv = w;
        for (int i = WIDTH - 1; i >= 0; i--) begin
`ifdef DESER_PARITY_EN
            step(1'b0, (i == WIDTH - 1), 1'b1, wv[i], 1'b0);
`else
            step(1'b0, (i == WIDTH - 1), 1'b1, wv[i], (i == 0) ? rdy_last : 1'b0);
`endif
        end
`ifdef DESER_PARITY_EN
        step(1'b0, 1'b0, 1'b1, (^wv) ^ par_flip, rdy_last);
`endif
    endtask

    task automatic test_reset;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({o_data, o_valid, o_overrun, o_busy} !== {4'h0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset: data=%h valid=%b ovr=%b busy=%b, required all zero",
                     o_data, o_valid, o_overrun, o_busy);
        end
    endtask

    task automatic test_frame;
        send_word(4'hA, 1'b0);
        checks++;
        if (o_valid !== 1'b1 || o_data !== 4'hA) begin
            errors++;
            $display("FAIL frame_deliver: valid=%b data=%h, required 1 a", o_valid, o_data);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (o_valid !== 1'b0) begin
            errors++;
            $display("FAIL frame_consume: valid=%b, required 0", o_valid);
        end
    endtask

    task automatic test_gapped;
        int busy_bad;
        busy_bad = 0;
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        if (o_busy !== 1'b1) busy_bad++;
        for (int g = 0; g < 3; g++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            if (o_busy !== 1'b1) busy_bad++;
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        if (o_busy !== 1'b1) busy_bad++;
`ifdef DESER_PARITY_EN
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
`else
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
`endif
        checks++;
        if (busy_bad != 0) begin
            errors++;
            $display("FAIL gapped_busy: busy low in %0d sampled cycles, required 0", busy_bad);
        end
        checks++;
        if (o_valid !== 1'b1 || o_data !== 4'hC || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL gapped_word: valid=%b data=%h busy=%b, required 1 c 0", o_valid, o_data, o_busy);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_restart;
        int ovr_seen;
        ovr_seen = 0;
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < WIDTH + 1; i++) begin
            if (i == 0) send_word(4'h7, 1'b0);
            if (o_overrun !== 1'b0) ovr_seen++;
        end
        checks++;
        if (o_valid !== 1'b1 || o_data !== 4'h7 || ovr_seen != 0) begin
            errors++;
            $display("FAIL restart: valid=%b data=%h overruns=%0d, required 1 7 0", o_valid, o_data, ovr_seen);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_overrun;
        send_word(4'hA, 1'b0);
        send_word(4'h5, 1'b0);
        checks++;
        if (o_overrun !== 1'b1 || o_data !== 4'hA || o_valid !== 1'b1) begin
            errors++;
            $display("FAIL overrun_pulse: ovr=%b data=%h valid=%b, required 1 a 1", o_overrun, o_data, o_valid);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (o_overrun !== 1'b0 || o_data !== 4'hA) begin
            errors++;
            $display("FAIL overrun_once: ovr=%b data=%h, required 0 a", o_overrun, o_data);
        end
        send_word(4'h5, 1'b1);
        checks++;
        if (o_overrun !== 1'b0 || o_data !== 4'h5 || o_valid !== 1'b1) begin
            errors++;
            $display("FAIL overrun_swap: ovr=%b data=%h valid=%b, required 0 5 1", o_overrun, o_data, o_valid);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid;
        send_word(4'h9, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (o_busy !== 1'b0 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b valid=%b, required 0 0", o_busy, o_valid);
        end
        send_word(4'h3, 1'b0);
        checks++;
        if (o_valid !== 1'b1 || o_data !== 4'h3) begin
            errors++;
            $display("FAIL reset_mid_frame: valid=%b data=%h, required 1 3", o_valid, o_data);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

`ifdef DESER_PARITY_EN
    task automatic test_parity;
        par_flip = 1'b0;
        send_word(4'hA, 1'b0);
        checks++;
        if (o_perr !== 1'b0 || o_data !== 4'hA || o_valid !== 1'b1) begin
            errors++;
            $display("FAIL parity_good: perr=%b data=%h valid=%b, required 0 a 1", o_perr, o_data, o_valid);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        par_flip = 1'b1;
        send_word(4'hA, 1'b0);
        checks++;
        if (o_perr !== 1'b1 || o_data !== 4'hA || o_valid !== 1'b1) begin
            errors++;
            $display("FAIL parity_bad: perr=%b data=%h valid=%b, required 1 a 1", o_perr, o_data, o_valid);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (o_perr !== 1'b0 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL parity_clear: perr=%b valid=%b, required 0 0", o_perr, o_valid);
        end
        par_flip = 1'b0;
    endtask
`endif

    task automatic test_random;
        logic r_rst, r_st, r_vld, r_d, r_rdy;
        int   perr_act;
        for (int n = 0; n < 600; n++) begin
            r_rst = ($urandom_range(0, 63) == 0);
            r_st  = ($urandom_range(0, 5) == 0);
            r_vld = ($urandom_range(0, 3) != 0);
            r_d   = 1'($urandom_range(0, 1));
            r_rdy = ($urandom_range(0, 2) == 0);
            step(r_rst, r_st, r_vld, r_d, r_rdy);
`ifdef DESER_PARITY_EN
            perr_act = int'(o_perr);
`else
            perr_act = 0;
`endif
            checks++;
            if (o_data !== m_data || o_valid !== m_valid || o_overrun !== m_ovr ||
                o_busy !== m_busy || perr_act != int'(m_perr)) begin
                errors++;
                $display("FAIL random[%0d]: data=%h valid=%b ovr=%b busy=%b perr=%0d, required %h %b %b %b %0d",
                         n, o_data, o_valid, o_overrun, o_busy, perr_act,
                         m_data, m_valid, m_ovr, m_busy, m_perr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_gapped();
        test_restart();
        test_overrun();
        test_reset_mid();
`ifdef DESER_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
